fft_peak_sink: RTL and testbench

FFT_PEAK_SINK -- requirements
Module: fft_peak_sink

---
 rtl/fft_peak_sink.sv | 163 ++++++++++++++++
 tb/tb_fft_peak_sink.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_sink.sv
// Per-frame peak search over |X|^2; frame_done rises 3 edges after the last bin is accepted.
// Ready drops for 4 cycles per frame; optional PEAK_SKIP_DC_EN removes bin 0 from the search.
module fft_peak_sink #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 512
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [2*DATA_W-1:0]       s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
    output logic [2*DATA_W-1:0]       peak_mag,
    output logic                      frame_done,
    output logic                      frame_err
);

    localparam int BIN_W = $clog2(FRAME_LEN);
    localparam int MAG_W = 2 * DATA_W;

    typedef enum logic [1:0] {ACCUM, FLUSH1, FLUSH2, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rdy;
    logic               accept;
    logic               last_bin;
    logic               eligible;
    logic [BIN_W-1:0]   bin_cnt;

    logic signed [MAG_W-1:0] re_x;
    logic signed [MAG_W-1:0] im_x;
    logic [MAG_W-2:0]   re_sq;
    logic [MAG_W-2:0]   im_sq;

    logic               s1_vld;
    logic [MAG_W-2:0]   s1_re_sq;
    logic [MAG_W-2:0]   s1_im_sq;
    logic [BIN_W-1:0]   s1_bin;

    logic [MAG_W-1:0]   mag;
    logic               upd;

    logic               run_have;
    logic [MAG_W-1:0]   run_mag;
    logic [BIN_W-1:0]   run_bin;
    logic               run_err;

    logic [MAG_W-1:0]   res_mag;
    logic [BIN_W-1:0]   res_bin;
    logic               res_err;

    assign s_tready = rdy;
    assign accept   = s_tvalid && rdy;
    assign last_bin = (bin_cnt == BIN_W'(FRAME_LEN - 1));

`ifdef PEAK_SKIP_DC_EN
    assign eligible = (bin_cnt != '0);
`else
    assign eligible = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_bin) state_nxt = FLUSH1;
            FLUSH1:  state_nxt = FLUSH2;
            FLUSH2:  state_nxt = DONE;
            DONE:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Ready is registered so it stays low through reset and re-opens the cycle after DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ACCUM;
            rdy   <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy   <= (state == ACCUM) && (state_nxt == ACCUM);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_cnt <= '0;
        end else if (accept) begin
            bin_cnt <= bin_cnt + BIN_W'(1);
        end
    end

    // Squares are non-negative, so the unsigned (2*DATA_W-1)-bit field holds (-2^(W-1))^2 exactly.
    assign re_x  = {{DATA_W{s_tdata[DATA_W-1]}}, s_tdata[DATA_W-1:0]};
    assign im_x  = {{DATA_W{s_tdata[MAG_W-1]}}, s_tdata[MAG_W-1:DATA_W]};
    assign re_sq = (MAG_W-1)'(re_x * re_x);
    assign im_sq = (MAG_W-1)'(im_x * im_x);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld   <= 1'b0;
            s1_re_sq <= '0;
            s1_im_sq <= '0;
            s1_bin   <= '0;
        end else begin
            s1_vld   <= accept && eligible;
            s1_re_sq <= re_sq;
            s1_im_sq <= im_sq;
            s1_bin   <= bin_cnt;
        end
    end

    assign mag = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
    assign upd = s1_vld && (!run_have || (mag > run_mag));

    // Entering DONE snapshots the frame result and clears the running state for the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_have <= 1'b0;
            run_mag  <= '0;
            run_bin  <= '0;
            run_err  <= 1'b0;
            res_mag  <= '0;
            res_bin  <= '0;
            res_err  <= 1'b0;
        end else if (state_nxt == DONE) begin
            res_mag  <= run_mag;
            res_bin  <= run_bin;
            res_err  <= run_err;
            run_have <= 1'b0;
            run_mag  <= '0;
            run_bin  <= '0;
            run_err  <= 1'b0;
        end else begin
            if (upd) begin
                run_have <= 1'b1;
                run_mag  <= mag;
                run_bin  <= s1_bin;
            end
            if (accept && (s_tlast != last_bin)) begin
                run_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak_bin   <= '0;
            peak_mag   <= '0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DONE);
            if (state == DONE) begin
                peak_bin  <= res_bin;
                peak_mag  <= res_mag;
                frame_err <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_sink.sv
// Scoreboard bench for fft_peak_sink: a reference peak model feeds an expectation queue
// that is drained and compared on every frame_done pulse.
module tb_fft_peak_sink;

    localparam int N = 512;

    typedef struct {
        logic [8:0]  bin;
        logic [63:0] mag;
        logic        err;
        longint      done_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [8:0]  peak_bin;
    logic [63:0] peak_mag;
    logic        frame_done;
    logic        frame_err;

    logic signed [31:0] re_a [N];
    logic signed [31:0] im_a [N];

    exp_t   sb [$];
    exp_t   mon_e;
    longint cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    bit     chk_rdy_next = 1'b0;

    fft_peak_sink #(.DATA_W(32), .FRAME_LEN(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] sq(input logic signed [31:0] v);
        longint s;
        s = v;
        return 64'(s * s);
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            re_a[i] = '0;
            im_a[i] = '0;
        end
    endtask

    // Returns at a negedge; the beat is accepted on the following posedge.
    task automatic send_beat(input logic [63:0] d, input bit last, input bit gaps);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                chk("ready_timeout", {63'd0, s_tready}, 64'd1);
                break;
            end
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_tvalid = 1'b0;
                continue;
            end
            s_tdata  = d;
            s_tlast  = last;
            s_tvalid = 1'b1;
            if (s_tready) break;
        end
    endtask

    task automatic run_frame(input int last_pos, input bit gaps);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] best;
        int          bb;
        bit          have;
        have = 1'b0;
        best = '0;
        bb   = 0;
        for (int i = 0; i < N; i++) begin
`ifdef PEAK_SKIP_DC_EN
            if (i == 0) continue;
`endif
            m = sq(re_a[i]) + sq(im_a[i]);
            if (!have || (m > best)) begin
                best = m;
                bb   = i;
                have = 1'b1;
            end
        end
        e.bin = 9'(bb);
        e.mag = best;
        e.err = (last_pos != N - 1);
        for (int i = 0; i < N; i++) begin
            send_beat({im_a[i], re_a[i]}, (i == last_pos), gaps);
            if (i == N - 1) begin
                e.done_edge = cyc + 4;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tready"}, {63'd0, s_tready}, 64'd0);
        chk({pfx, "_peak_bin"}, {55'd0, peak_bin}, 64'd0);
        chk({pfx, "_peak_mag"}, peak_mag, 64'd0);
        chk({pfx, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({pfx, "_frame_err"}, {63'd0, frame_err}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (chk_rdy_next) begin
            chk("rdy_after_done", {63'd0, s_tready}, 64'd1);
            chk("done_pulse_width", {63'd0, frame_done}, 64'd0);
            chk_rdy_next = 1'b0;
        end else if (resetn && frame_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, frame_done}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("peak_bin", {55'd0, peak_bin}, {55'd0, mon_e.bin});
                chk("peak_mag", peak_mag, mon_e.mag);
                chk("frame_err", {63'd0, frame_err}, {63'd0, mon_e.err});
                chk("done_latency", 64'(cyc), 64'(mon_e.done_edge));
                chk("rdy_in_done", {63'd0, s_tready}, 64'd0);
                chk_rdy_next = 1'b1;
            end
        end
    end

    initial begin
        clear_frame();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", {63'd0, s_tready}, 64'd1);

        // Single strong bin
        clear_frame();
        re_a[37] = 1000;
        im_a[37] = -1000;
        run_frame(N - 1, 1'b0);

        // Equal magnitudes: lower bin wins
        clear_frame();
        re_a[10]  = 3;  im_a[10]  = 4;
        re_a[200] = 3;  im_a[200] = 4;
        run_frame(N - 1, 1'b0);

        // DC bin eligibility depends on build option
        clear_frame();
        re_a[0] = 5000;
        re_a[9] = 100;
        run_frame(N - 1, 1'b0);

        // Misplaced tlast with random valid gaps, then a clean frame
        clear_frame();
        re_a[123] = -70000;
        im_a[123] = 12;
        run_frame(300, 1'b1);
        clear_frame();
        re_a[77] = -9;
        im_a[77] = 2;
        run_frame(N - 1, 1'b1);

        // Most negative components on both axes
        clear_frame();
        re_a[5] = 32'sh8000_0000;
        im_a[5] = 32'sh8000_0000;
        run_frame(N - 1, 1'b0);

        // Reset in the middle of a frame, then a full clean frame
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        clear_frame();
        re_a[50] = 30000;
        for (int i = 0; i < 200; i++) begin
            send_beat({im_a[i], re_a[i]}, 1'b0, 1'b0);
        end
        @(negedge clk);
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_midreset", {63'd0, s_tready}, 64'd1);
        clear_frame();
        re_a[400] = 7;
        im_a[400] = -7;
        run_frame(N - 1, 1'b0);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
